bcd_bin_seq_converter_cgrundey: RTL and testbench
=================================================

// Module: bcd_bin_seq_converter_cgrundey
// PURPOSE
//   Iterative, parametrised bidirectional BCD <-> binary converter with a start/done handshake.
//   Successor to the fixed 6-bit combinational SN184/SN185-style converters.
//   Width and digit count are set by parameters, and each conversion selects a run-time mode.
//   Uses shift-and-add-3 (double dabble) for binary->BCD and shift-and-subtract-3 (reverse dabble) for BCD->binary.
//   Sits between the 6-bit counter/datapath and display/keypad logic.
// PARAMETERS
//   BIN_W   8  binary operand width in bits (>=2); also the iteration count for both modes
//   DIGITS  3  BCD digit count; BCD bus width = 4*DIGITS; 10**DIGITS must exceed 2**BIN_W-1
// PORTS
//   clk       in   1         single clock; all state changes on the rising edge
//   clear_n   in   1         asynchronous, active-low reset
//   en_n      in   1         active-low enable; when 1, all state and outputs hold (FSM frozen)
//   start     in   1         request; sampled only in IDLE or DONE with en_n=0
//   mode      in   1         0 = binary->BCD, 1 = BCD->binary; sampled with start
//   bin_in    in   BIN_W     binary operand (mode 0)
//   bcd_in    in   4*DIGITS  BCD operand (mode 1); digit 0 is bits [3:0]
//   busy      out  1         1 while converting
//   done      out  1         one-cycle pulse; results/err are valid from this cycle on
//   err       out  1         1 = last conversion failed (invalid digit or overflow)
//   bin_out   out  BIN_W     binary result (mode 1); 0 after a mode-0 conversion
//   bcd_out   out  4*DIGITS  BCD result (mode 0); 0 after a mode-1 conversion
// BEHAVIOUR
//   Reset (clear_n=0, async): state=IDLE; busy=0, done=0, err=0, bin_out=0, bcd_out=0.
//   States:
//     IDLE: start=1 -> CONV, or ERR_CHK path, on the same edge.
//     CONV: runs BIN_W iterations, then -> DONE.
//     DONE: lasts 1 cycle -> IDLE, or -> CONV if start=1 in that cycle (back-to-back).
//   Operand capture (edge E where start is accepted): operand and mode go into an internal shift register, iteration counter=0.
//     Operands are never re-read after capture; changes to inputs mid-conversion are ignored.
//   Mode 0 iteration: every BCD nibble >=5 gets +3, then {bcd,bin} shifts left by 1.
//   Mode 1 iteration: {bcd,bin} shifts right by 1, then every BCD nibble >=8 gets -3.
//   Timing:
//     busy=1 in cycles following edges E..E+BIN_W-1.
//     At edge E+BIN_W: result registers load, done=1 for exactly one cycle, busy=0.
//     Latency start->done = BIN_W cycles (8 at defaults).
//   Mode 1 overflow: if the BCD portion is nonzero after BIN_W iterations, err=1 and bin_out=0.
//   Mode 1 invalid digit: if any bcd_in nibble >9 at capture, no CONV is run.
//     Next edge: done=1, err=1, bin_out=0, bcd_out=0 (latency 1).
//   Mode 0 never sets err, given the parameter constraint.
//   Result outputs and err hold until the next done; start clears nothing early.
//   start while busy=1: ignored, no queueing.
//   en_n=1 mid-CONV: iteration counter and shift register freeze; resumes on en_n=0; done latency extends by the stalled cycles.
//   en_n=1 during a DONE cycle: done stays 1 until en_n=0 (so the pulse is not lost).
//   clear_n asserted mid-conversion: immediate return to reset values; no done is produced.
// TESTING (BIN_W=8, DIGITS=3)
//   1. Reset mid-CONV (after mode0 bin_in=8'd200, 3 cycles) -> all outputs 0 immediately; no done pulse.
//   2. Mode 0, bin_in=8'd255 -> done 8 cycles after start; bcd_out=12'h255, err=0.
//      Mode 0, bin_in=0 -> bcd_out=12'h000. Mode 0, bin_in=8'd128 -> bcd_out=12'h128.
//   3. Mode 1, bcd_in=12'h199 -> bin_out=8'd199 (8'hC7), err=0.
//      Mode 1, bcd_in=12'h255 -> bin_out=8'hFF.
//   4. Mode 1, bcd_in=12'h300 -> done after 8 cycles, err=1, bin_out=0 (overflow).
//      Mode 1, bcd_in=12'h1A0 -> done after 1 cycle, err=1 (invalid digit).
//   5. Start re-pulsed while busy -> ignored; result is still for the first operand.
//      Start during the DONE cycle -> second conversion done exactly 8 cycles later.
//   6. en_n=1 for 4 cycles mid-CONV (mode 0, bin_in=8'd99) -> done at 12 cycles, bcd_out=12'h099.
//      en_n=1 during DONE -> done held until release.

Source files
------------

// File: rtl/bcd_bin_seq_converter_cgrundey.sv
// Iterative bidirectional BCD <-> binary converter with a start/done handshake.
// Mode 0 runs double dabble (add-3, shift left); mode 1 runs reverse dabble (shift right, subtract-3).
module bcd_bin_seq_converter_cgrundey #(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  clear_n,
   input  logic                  en_n,
   input  logic                  start,
   input  logic                  mode,
   input  logic [BIN_W-1:0]      bin_in,
   input  logic [4*DIGITS-1:0]   bcd_in,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [BIN_W-1:0]      bin_out,
   output logic [4*DIGITS-1:0]   bcd_out
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int SR_W  = BCD_W + BIN_W;
   localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONV    = 2'd1,
      ERR_CHK = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [SR_W-1:0]    sr_q, sr_d, sr_step;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               mode_q, mode_d;
   logic               err_q, err_d;
   logic [BIN_W-1:0]   bin_q, bin_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d;
   logic               bcd_invalid;

   // Shift register layout is {bcd, bin} in both modes.
   function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] sr, input logic m);
      logic [SR_W-1:0] t;
      t = m ? (sr >> 1) : sr;
      for (int i = 0; i < DIGITS; i++) begin
         if (!m && t[BIN_W+4*i +: 4] >= 4'd5)
            t[BIN_W+4*i +: 4] = t[BIN_W+4*i +: 4] + 4'd3;
         else if (m && t[BIN_W+4*i +: 4] >= 4'd8)
            t[BIN_W+4*i +: 4] = t[BIN_W+4*i +: 4] - 4'd3;
      end
      return m ? t : (t << 1);
   endfunction

   always_comb begin
      bcd_invalid = 1'b0;
      for (int i = 0; i < DIGITS; i++)
         if (bcd_in[4*i +: 4] > 4'd9) bcd_invalid = 1'b1;
   end

   assign sr_step = dabble_step(sr_q, mode_q);

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state_q <= IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
         mode_q  <= 1'b0;
         err_q   <= 1'b0;
         bin_q   <= '0;
         bcd_q   <= '0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         err_q   <= err_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      err_d   = err_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      if (!en_n) begin
         case (state_q)
            IDLE, DONE: begin
               state_d = IDLE;
               if (start) begin
                  mode_d = mode;
                  cnt_d  = '0;
                  if (mode && bcd_invalid) begin
                     state_d = ERR_CHK;
                  end else begin
                     state_d = CONV;
                     sr_d    = mode ? {bcd_in, {BIN_W{1'b0}}} : {{BCD_W{1'b0}}, bin_in};
                  end
               end
            end
            CONV: begin
               sr_d  = sr_step;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST_ITER) begin
                  state_d = DONE;
                  if (mode_q) begin
                     // Leftover BCD weight means the value does not fit in BIN_W bits.
                     err_d = |sr_step[SR_W-1 -: BCD_W];
                     bin_d = err_d ? '0 : sr_step[BIN_W-1:0];
                     bcd_d = '0;
                  end else begin
                     err_d = 1'b0;
                     bin_d = '0;
                     bcd_d = sr_step[SR_W-1 -: BCD_W];
                  end
               end
            end
            ERR_CHK: begin
               state_d = DONE;
               err_d   = 1'b1;
               bin_d   = '0;
               bcd_d   = '0;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign busy    = (state_q == CONV) || (state_q == ERR_CHK);
   assign done    = (state_q == DONE);
   assign err     = err_q;
   assign bin_out = bin_q;
   assign bcd_out = bcd_q;

endmodule

// File: tb/tb_bcd_bin_seq_converter_cgrundey.sv
// Directed bench for bcd_bin_seq_converter_cgrundey at BIN_W=8, DIGITS=3.
module tb_bcd_bin_seq_converter_cgrundey;

   logic        clk = 1'b0;
   logic        clear_n = 1'b0;
   logic        en_n = 1'b0;
   logic        start = 1'b0;
   logic        mode = 1'b0;
   logic [7:0]  bin_in = '0;
   logic [11:0] bcd_in = '0;
   logic        busy, done, err;
   logic [7:0]  bin_out;
   logic [11:0] bcd_out;

   int tests = 0;
   int fails = 0;
   int lat;
   logic seen;

   bcd_bin_seq_converter_cgrundey #(.BIN_W(8), .DIGITS(3)) dut (
      .clk(clk), .clear_n(clear_n), .en_n(en_n), .start(start), .mode(mode),
      .bin_in(bin_in), .bcd_in(bcd_in), .busy(busy), .done(done), .err(err),
      .bin_out(bin_out), .bcd_out(bcd_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drives start for one rising edge; returns #1 after that capture edge.
   task automatic pulse_start(input logic m, input logic [7:0] b, input logic [11:0] d);
      mode = m; bin_in = b; bcd_in = d; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      bin_in = 8'hAA; bcd_in = 12'h777;
   endtask

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // Counts rising edges until done is seen; bounded.
   task automatic wait_done(output int cycles);
      cycles = 0;
      while (cycles < 40) begin
         @(posedge clk); #1;
         cycles++;
         if (done) break;
      end
   endtask

   initial begin
      #12;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_bin", bin_out, 0);
      check("rst_bcd", bcd_out, 0);
      clear_n = 1'b1;
      @(negedge clk);

      pulse_start(1'b0, 8'd255, 12'h0);
      check("m0_255_busy", busy, 1);
      wait_done(lat);
      check("m0_255_lat", lat, 8);
      check("m0_255_bcd", bcd_out, 12'h255);
      check("m0_255_err", err, 0);
      check("m0_255_bin", bin_out, 0);
      step(1);
      check("done_pulse_1cyc", done, 0);

      // Reset mid-conversion
      pulse_start(1'b0, 8'd200, 12'h0);
      step(3);
      clear_n = 1'b0; #1;
      check("rstmid_busy", busy, 0);
      check("rstmid_bcd", bcd_out, 0);
      check("rstmid_err", err, 0);
      check("rstmid_done", done, 0);
      @(negedge clk); clear_n = 1'b1;
      seen = 1'b0;
      repeat (12) begin @(posedge clk); #1; seen = seen | done; end
      check("rstmid_no_done", seen, 0);

      pulse_start(1'b0, 8'd0, 12'h0);
      wait_done(lat);
      check("m0_0_bcd", bcd_out, 12'h000);
      pulse_start(1'b0, 8'd128, 12'h0);
      wait_done(lat);
      check("m0_128_bcd", bcd_out, 12'h128);

      pulse_start(1'b1, 8'h0, 12'h199);
      wait_done(lat);
      check("m1_199_lat", lat, 8);
      check("m1_199_bin", bin_out, 8'hC7);
      check("m1_199_err", err, 0);
      check("m1_199_bcd", bcd_out, 0);

      pulse_start(1'b1, 8'h0, 12'h255);
      wait_done(lat);
      check("m1_255_bin", bin_out, 8'hFF);

      pulse_start(1'b1, 8'h0, 12'h300);
      wait_done(lat);
      check("m1_300_lat", lat, 8);
      check("m1_300_err", err, 1);
      check("m1_300_bin", bin_out, 0);

      pulse_start(1'b1, 8'h0, 12'h1A0);
      wait_done(lat);
      check("m1_inv_lat", lat, 1);
      check("m1_inv_err", err, 1);
      check("m1_inv_bin", bin_out, 0);
      check("m1_inv_bcd", bcd_out, 0);

      // Start while busy is ignored
      pulse_start(1'b0, 8'd42, 12'h0);
      step(2);
      pulse_start(1'b1, 8'h0, 12'h199);
      wait_done(lat);
      check("busy_start_lat", lat + 3, 8);
      check("busy_start_bcd", bcd_out, 12'h042);
      check("busy_start_err", err, 0);

      // Back-to-back start in the DONE cycle
      pulse_start(1'b1, 8'h0, 12'h255);
      check("b2b_busy", busy, 1);
      wait_done(lat);
      check("b2b_lat", lat, 8);
      check("b2b_bin", bin_out, 8'hFF);
      check("b2b_bcd", bcd_out, 0);

      // Enable stall mid-conversion
      step(1);
      pulse_start(1'b0, 8'd99, 12'h0);
      step(3);
      en_n = 1'b1;
      step(4);
      check("stall_busy", busy, 1);
      check("stall_done", done, 0);
      en_n = 1'b0;
      wait_done(lat);
      check("stall_lat", lat + 7, 12);
      check("stall_bcd", bcd_out, 12'h099);

      // Enable held during DONE keeps the pulse
      en_n = 1'b1;
      step(3);
      check("hold_done", done, 1);
      check("hold_bcd", bcd_out, 12'h099);
      en_n = 1'b0;
      step(1);
      check("hold_release", done, 0);
      check("hold_result_kept", bcd_out, 12'h099);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
